cache_refill_arbiter: RTL and testbench

- Shares the single external memory port between ICache line fills and DCache line fills/writebacks.
- Grants one line transaction at a time and runs a multi-beat burst: line = LINE_WIDTH bits, BEATS = LINE_WIDTH/BUS_WIDTH beats.
- Assembles read beats into a full line and returns it to the requesting cache.
- Sits between the ICache/DCache miss units and the core memory interface.

---
 rtl/cache_refill_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cache_refill_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one external memory port between ICache line fills and DCache
//   line fills/writebacks. One line transaction is granted at a time and
//   is run as a BEATS-long burst (BEATS = LINE_WIDTH/BUS_WIDTH). Read beats
//   are assembled into a full line that is returned to the requester.
//
//   Build option: define REFILL_ARB_DCACHE_PRIO_EN to make the DCache win
//   every IDLE arbitration (fixed priority, no round-robin pointer).
//   Without it, ICache and DCache alternate priority after each grant.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   ic_req_* / ic_rsp_*    ICache fill request and one-cycle line response
//   dc_req_* / dc_rsp_*    DCache fill/writeback request and one-cycle response
//   mem_req_*              burst address phase (valid/ready)
//   mem_w*                 write beats (valid/ready, last on final beat)
//   mem_rvalid_i/rdata_i   read beats, no backpressure
//   mem_bvalid_i           write burst completion
module cache_refill_arbiter #(
  parameter int PLEN       = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BUS_WIDTH  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_req_valid_i,
  output logic                  ic_req_ready_o,
  input  logic [PLEN-1:0]       ic_req_addr_i,
  output logic                  ic_rsp_valid_o,
  output logic [LINE_WIDTH-1:0] ic_rsp_data_o,
  input  logic                  dc_req_valid_i,
  output logic                  dc_req_ready_o,
  input  logic                  dc_req_we_i,
  input  logic [PLEN-1:0]       dc_req_addr_i,
  input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
  output logic                  dc_rsp_valid_o,
  output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PLEN-1:0]       mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  output logic                  mem_wlast_o,
  input  logic                  mem_rvalid_i,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
  input  logic                  mem_bvalid_i
);

  localparam int BEATS    = LINE_WIDTH / BUS_WIDTH;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W    = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRESP, S_RDATA, S_RESP
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        beat_reg, beat_next;
  logic [PLEN-1:0]         addr_reg;
  logic                    we_reg;
  logic                    gnt_dc_reg;
  logic                    dc_wb_reg;     // last DCache transaction was a writeback
  logic [LINE_WIDTH-1:0]   wdata_reg;
  logic [LINE_WIDTH-1:0]   line_data;
  logic [BUS_WIDTH-1:0]    wbeat [BEATS];
  logic                    pick_ic, pick_dc, accept;
  logic [PLEN-1:0]         sel_addr;

  // ---------------- arbitration ----------------
`ifdef REFILL_ARB_DCACHE_PRIO_EN
  assign pick_dc = dc_req_valid_i;
  assign pick_ic = ic_req_valid_i & ~dc_req_valid_i;
`else
  logic rr_dc_reg;  // 1: DCache has priority on a tie

  assign pick_dc = dc_req_valid_i & (~ic_req_valid_i | rr_dc_reg);
  assign pick_ic = ic_req_valid_i & (~dc_req_valid_i | ~rr_dc_reg);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_dc_reg <= 1'b0;
    end else if (accept) begin
      // The requester that just lost (or was absent) gets the next tie.
      rr_dc_reg <= ~dc_req_ready_o;
    end
  end
`endif

  // Readies are gated by reset so nothing is accepted while it is asserted.
  assign ic_req_ready_o = (state_reg == S_IDLE) & ~rst_i & pick_ic;
  assign dc_req_ready_o = (state_reg == S_IDLE) & ~rst_i & pick_dc;
  assign accept         = ic_req_ready_o | dc_req_ready_o;
  assign sel_addr       = dc_req_ready_o ? dc_req_addr_i : ic_req_addr_i;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    mem_req_valid_o = 1'b0;
    mem_wvalid_o    = 1'b0;
    mem_wlast_o     = 1'b0;
    ic_rsp_valid_o  = 1'b0;
    dc_rsp_valid_o  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_ADDR;
      end
      S_ADDR: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_next = we_reg ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        mem_wvalid_o = 1'b1;
        mem_wlast_o  = (beat_reg == LAST_BEAT);
        if (mem_wready_i) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = S_WRESP;
          end else begin
            beat_next = beat_reg + CNT_W'(1);
          end
        end
      end
      S_WRESP: begin
        if (mem_bvalid_i) state_next = S_RESP;
      end
      S_RDATA: begin
        if (mem_rvalid_i) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = S_RESP;
          end else begin
            beat_next = beat_reg + CNT_W'(1);
          end
        end
      end
      S_RESP: begin
        ic_rsp_valid_o = ~gnt_dc_reg;
        dc_rsp_valid_o = gnt_dc_reg;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- request latch ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dc_wb_reg <= 1'b0;
    end else if (accept) begin
      addr_reg   <= {sel_addr[PLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
      we_reg     <= dc_req_ready_o & dc_req_we_i;
      gnt_dc_reg <= dc_req_ready_o;
      dc_wb_reg  <= dc_req_ready_o & dc_req_we_i;
      if (dc_req_ready_o) wdata_reg <= dc_req_wdata_i;
    end
  end

  // ---------------- beat datapath ----------------
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    logic [BUS_WIDTH-1:0] rbeat_reg;

    assign wbeat[gi] = wdata_reg[gi*BUS_WIDTH +: BUS_WIDTH];
    assign line_data[gi*BUS_WIDTH +: BUS_WIDTH] = rbeat_reg;

    // Data registers need no reset; content is undefined until first fill.
    always_ff @(posedge clk_i) begin
      if (!rst_i && state_reg == S_RDATA && mem_rvalid_i && beat_reg == CNT_W'(gi))
        rbeat_reg <= mem_rdata_i;
    end
  end

  assign mem_wdata_o    = wbeat[beat_reg];
  assign mem_req_addr_o = addr_reg;
  assign mem_req_we_o   = we_reg;
  assign ic_rsp_data_o  = line_data;
  assign dc_rsp_data_o  = dc_wb_reg ? '0 : line_data;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         ic_req_valid_i, ic_req_ready_o, ic_rsp_valid_o;
  logic [31:0]  ic_req_addr_i;
  logic [255:0] ic_rsp_data_o;
  logic         dc_req_valid_i, dc_req_ready_o, dc_req_we_i, dc_rsp_valid_o;
  logic [31:0]  dc_req_addr_i;
  logic [255:0] dc_req_wdata_i, dc_rsp_data_o;
  logic         mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [31:0]  mem_req_addr_o;
  logic         mem_wvalid_o, mem_wready_i, mem_wlast_o;
  logic [63:0]  mem_wdata_o, mem_rdata_i;
  logic         mem_rvalid_i, mem_bvalid_i;

  always #5 clk = ~clk;

  cache_refill_arbiter #(.PLEN(32), .LINE_WIDTH(256), .BUS_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
    .ic_req_addr_i(ic_req_addr_i), .ic_rsp_valid_o(ic_rsp_valid_o),
    .ic_rsp_data_o(ic_rsp_data_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
    .dc_req_we_i(dc_req_we_i), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_wdata_i(dc_req_wdata_i), .dc_rsp_valid_o(dc_rsp_valid_o),
    .dc_rsp_data_o(dc_rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i),
    .mem_wdata_o(mem_wdata_o), .mem_wlast_o(mem_wlast_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_bvalid_i(mem_bvalid_i)
  );

  // Scoreboard event kinds
  localparam int K_ADDR = 0, K_WBEAT = 1, K_ICRSP = 2, K_DCRSP = 3;

  typedef struct {
    int           kind;
    logic [255:0] data;
    logic         flag;   // we for ADDR, wlast for WBEAT
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [255:0] data, input logic flag);
    ev_t e;
    e.kind = kind; e.data = data; e.flag = flag;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [255:0] data, input logic flag,
                          input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event data=%h", name, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data || e.flag !== flag) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d data=%h flag=%b expected kind=%0d data=%h flag=%b",
                 name, kind, data, flag, e.kind, e.data, e.flag);
      end else if (kind == K_ICRSP || kind == K_DCRSP) begin
        $display("txn %s data=%h", name, data);
      end
    end
  endtask

  // Monitor: compares every observable handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (mem_req_valid_o && mem_req_ready_i)
        check_ev(K_ADDR, {224'b0, mem_req_addr_o}, mem_req_we_o, "mem_addr");
      if (mem_wvalid_o && mem_wready_i)
        check_ev(K_WBEAT, {192'b0, mem_wdata_o}, mem_wlast_o, "mem_wbeat");
      if (ic_rsp_valid_o)
        check_ev(K_ICRSP, ic_rsp_data_o, 1'b0, "ic_rsp");
      if (dc_rsp_valid_o)
        check_ev(K_DCRSP, dc_rsp_data_o, 1'b0, "dc_rsp");
    end
  end

  function automatic logic [255:0] mk_line(input logic [63:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Raise a request and hold it until the matching ready is seen.
  task automatic request(input bit is_dc, input logic we, input logic [31:0] addr,
                         input logic [255:0] wdata);
    bit got = 0;
    if (is_dc) begin
      dc_req_valid_i = 1; dc_req_we_i = we; dc_req_addr_i = addr; dc_req_wdata_i = wdata;
    end else begin
      ic_req_valid_i = 1; ic_req_addr_i = addr;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = is_dc ? dc_req_ready_o : ic_req_ready_o;
      step();
    end
    ic_req_valid_i = 0; dc_req_valid_i = 0;
    chk(is_dc ? "dc_req_accept" : "ic_req_accept", got, 1'b1);
  endtask

  // Wait for the address phase, stall it for 'hold' cycles, then accept it.
  task automatic serve_addr(input int hold, input logic [31:0] exp_addr);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = mem_req_valid_o;
      step();
    end
    chk("mem_req_seen", got, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid_o, 1'b1);
      chk("stall_addr", mem_req_addr_o, exp_addr);
      chk("stall_readies", {ic_req_ready_o, dc_req_ready_o}, 2'b00);
      step();
    end
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
  endtask

  task automatic serve_read(input logic [255:0] line, input bit spur_b, input bit exp_dc);
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = 1; mem_rdata_i = line[k*64 +: 64];
      step();
      mem_rvalid_i = 0;
      if (spur_b && k == 1) begin
        mem_bvalid_i = 1;
        step();
        mem_bvalid_i = 0;
      end
    end
    @(negedge clk);
    chk(exp_dc ? "dc_rsp_pulse" : "ic_rsp_pulse",
        exp_dc ? dc_rsp_valid_o : ic_rsp_valid_o, 1'b1);
    step();
  endtask

  task automatic serve_write(input logic [255:0] line);
    int k = 0, stall = 2;
    for (int g = 0; g < 50 && k < 4; g++) begin
      mem_wready_i = !(k == 1 && stall > 0);
      @(negedge clk);
      if (mem_wvalid_o && mem_wready_i) begin
        k++;
      end else if (!mem_wready_i) begin
        stall--;
        chk("wbeat1_held_valid", mem_wvalid_o, 1'b1);
        chk("wbeat1_held_data", mem_wdata_o, line[127:64]);
      end
      step();
    end
    mem_wready_i = 0;
    chk("wbeat_count", k, 4);
    step();
    mem_bvalid_i = 1;
    step();
    mem_bvalid_i = 0;
    @(negedge clk);
    chk("dc_wb_pulse", dc_rsp_valid_o, 1'b1);
    step();
  endtask

  initial begin
    logic [255:0] l1, l2, l3, l4, l5, l6;
    bit           win_dc;
    rst_i = 1;
    ic_req_valid_i = 1; ic_req_addr_i = '0;
    dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0;
    mem_req_ready_i = 0; mem_wready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    mem_bvalid_i = 0;

    // Reset state: all handshake outputs low even with requests pending.
    repeat (3) step();
    @(negedge clk);
    chk("rst_readies", {ic_req_ready_o, dc_req_ready_o}, 2'b00);
    chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_wvalid", mem_wvalid_o, 1'b0);
    chk("rst_wlast", mem_wlast_o, 1'b0);
    chk("rst_rsp_valid", {ic_rsp_valid_o, dc_rsp_valid_o}, 2'b00);
    step();
    ic_req_valid_i = 0; dc_req_valid_i = 0; rst_i = 0;
    step();

    // ICache fill with unaligned address.
    l1 = mk_line(64'h11, 64'h22, 64'h33, 64'h44);
    push_ev(K_ADDR, 256'h8000_1220, 1'b0);
    push_ev(K_ICRSP, l1, 1'b0);
    request(0, 0, 32'h8000_1234, '0);
    serve_addr(0, 32'h8000_1220);
    serve_read(l1, 0, 0);

    // DCache writeback with wready stalled two cycles on beat 1.
    l2 = mk_line(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    push_ev(K_ADDR, 256'h0000_0040, 1'b1);
    for (int k = 0; k < 4; k++) push_ev(K_WBEAT, {192'b0, l2[k*64 +: 64]}, k == 3);
    push_ev(K_DCRSP, '0, 1'b0);
    request(1, 1, 32'h0000_0040, l2);
    serve_addr(0, 32'h0000_0040);
    serve_write(l2);

    // Simultaneous requests, three rounds back-to-back.
    for (int r = 0; r < 3; r++) begin
`ifdef REFILL_ARB_DCACHE_PRIO_EN
      win_dc = 1;
`else
      win_dc = (r == 1);
`endif
      l3 = mk_line(64'h300 + 64'(r), 64'h310 + 64'(r), 64'h320 + 64'(r), 64'h330 + 64'(r));
      push_ev(K_ADDR, win_dc ? 256'h0000_2000 : 256'h0000_1000, 1'b0);
      push_ev(win_dc ? K_DCRSP : K_ICRSP, l3, 1'b0);
      ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_1000;
      dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = 32'h0000_2000;
      @(negedge clk);
      chk("arb_grant", {ic_req_ready_o, dc_req_ready_o}, {!win_dc, win_dc});
      step();
      ic_req_valid_i = 0; dc_req_valid_i = 0;
      serve_addr(0, win_dc ? 32'h0000_2000 : 32'h0000_1000);
      serve_read(l3, 0, win_dc);
    end

    // Address phase stalled 5 cycles with both caches requesting.
    l4 = mk_line(64'h4000, 64'h4001, 64'h4002, 64'h4003);
    push_ev(K_ADDR, 256'h0000_2000, 1'b0);
    push_ev(K_ICRSP, l4, 1'b0);
    request(0, 0, 32'h0000_2008, '0);
    ic_req_valid_i = 1; dc_req_valid_i = 1; dc_req_we_i = 0;
    serve_addr(5, 32'h0000_2000);
    ic_req_valid_i = 0; dc_req_valid_i = 0;
    serve_read(l4, 0, 0);

    // Reset after two of four read beats, then stray beats.
    push_ev(K_ADDR, 256'h0000_3000, 1'b0);
    request(0, 0, 32'h0000_3000, '0);
    serve_addr(0, 32'h0000_3000);
    for (int k = 0; k < 2; k++) begin
      mem_rvalid_i = 1; mem_rdata_i = 64'hBAD0 + 64'(k);
      step();
    end
    mem_rvalid_i = 0; rst_i = 1;
    @(negedge clk);
    chk("midrst_rsp_valid", {ic_rsp_valid_o, dc_rsp_valid_o}, 2'b00);
    step();
    rst_i = 0;
    @(negedge clk);
    chk("postrst_mem_req_valid", mem_req_valid_o, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      mem_rvalid_i = 1; mem_rdata_i = 64'hBAD2 + 64'(k);
      step();
    end
    mem_rvalid_i = 0;
    repeat (3) step();
    chk("queue_after_reset", exp_q.size(), 0);
    l5 = mk_line(64'h5000, 64'h5001, 64'h5002, 64'h5003);
    push_ev(K_ADDR, 256'h0000_3000, 1'b0);
    push_ev(K_ICRSP, l5, 1'b0);
    request(0, 0, 32'h0000_3004, '0);
    serve_addr(0, 32'h0000_3000);
    serve_read(l5, 0, 0);

    // Stray rvalid/bvalid in IDLE, spurious bvalid during RDATA.
    mem_rvalid_i = 1; mem_rdata_i = 64'hDEAD; mem_bvalid_i = 1;
    step();
    step();
    mem_rvalid_i = 0; mem_bvalid_i = 0;
    l6 = mk_line(64'h6000, 64'h6001, 64'h6002, 64'h6003);
    push_ev(K_ADDR, 256'h0000_4000, 1'b0);
    push_ev(K_DCRSP, l6, 1'b0);
    request(1, 0, 32'h0000_4010, '0);
    serve_addr(0, 32'h0000_4000);
    serve_read(l6, 1, 1);

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
